wb_regfile: RTL and testbench

- Write-back stage plus integer register file for the RV32I core.
- Consumes the execute units' result triple (reg_wdata, reg_we, reg_waddr) through a valid/ready handshake.
- Holds each result for one write-back cycle, then commits it to a 32-entry register array.
- Serves two combinational read ports to decode, with optional bypass from the WB stage and a retired-write counter.

---
 rtl/wb_regfile_pkg.sv | 25 ++
 rtl/regfile_array.sv | 39 +++
 rtl/wb_regfile.sv | 105 ++++++++++
 tb/tb_wb_regfile.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and constants for the write-back stage and register file
//
// Purpose : one place for the register file geometry and the write-enable encoding,
//           plus a helper that decides whether a WB entry really updates a register.
// Ports   : none (package).

package wb_regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;
    localparam int CNT_WIDTH  = 32;

    localparam logic [DATA_WIDTH-1:0] ZERO          = '0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [REG_ADDR_W-1:0] X0_ADDR       = '0;

    // An entry only touches architectural state when it asks for a write and does
    // not target x0; everything else is dropped at commit and never forwarded.
    function automatic logic is_reg_write(input logic we, input logic [REG_ADDR_W-1:0] addr);
        return (we == WRITE_ENABLE) && (addr != X0_ADDR);
    endfunction

endpackage

// File: rtl/regfile_array.sv
// rtl/regfile_array.sv - 32-entry integer register storage, one write port, two read ports
//
// Purpose : architectural register array with synchronous clear and x0 hardwired to zero.
// Ports   : clk_i, rst_i          - clock, synchronous active-high clear of every entry
//           we_i, waddr_i, wdata_i - synchronous write port (x0 writes ignored)
//           raddr1_i/rdata1_o      - combinational read port 1
//           raddr2_i/rdata2_o      - combinational read port 2

module regfile_array
    import wb_regfile_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    logic [DATA_WIDTH-1:0] mem [REG_NUM];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem[i] <= ZERO;
            end
        end else if (we_i && (waddr_i != X0_ADDR)) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // x0 is forced on the read side so the array itself never needs a special entry.
    assign rdata1_o = (raddr1_i == X0_ADDR) ? ZERO : mem[raddr1_i];
    assign rdata2_o = (raddr2_i == X0_ADDR) ? ZERO : mem[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - RV32I write-back stage and integer register file
//
// Purpose : accepts one execute result per cycle through a valid/ready handshake,
//           holds it for one write-back cycle, then commits it to the register array.
//           Counts committed register writes. Optional WB->read bypass under the
//           WB_BYPASS_EN macro (default build: reads see array contents only).
// Ports   : clk_i, rst_i                         - clock, synchronous active-high reset
//           ex_valid_i, ex_ready_o               - result handshake
//           reg_we_i, reg_waddr_i, reg_wdata_i   - result triple
//           hold_i                               - downstream stall, freezes the WB entry
//           raddr1_i/rdata1_o, raddr2_i/rdata2_o - combinational decode read ports
//           wb_busy_o                            - WB entry not yet committed
//           retired_o                            - committed register writes (wraps)

module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  reg_we_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic                  hold_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    output logic                  wb_busy_o,
    output logic [CNT_WIDTH-1:0]  retired_o
);

    logic                  wb_valid;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  accept;
    logic                  commit;
    logic                  commit_write;
    logic [DATA_WIDTH-1:0] arr_rdata1;
    logic [DATA_WIDTH-1:0] arr_rdata2;

    // A free slot, or a slot that drains this edge, can take a new result.
    assign ex_ready_o   = !wb_valid || !hold_i;
    assign accept       = ex_valid_i && ex_ready_o;
    assign commit       = wb_valid && !hold_i;
    assign commit_write = commit && is_reg_write(wb_we, wb_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid  <= 1'b0;
            wb_we     <= WRITE_DISABLE;
            wb_addr   <= X0_ADDR;
            wb_data   <= ZERO;
            retired_o <= '0;
        end else begin
            if (accept) begin
                wb_valid <= 1'b1;
                wb_we    <= reg_we_i;
                wb_addr  <= reg_waddr_i;
                wb_data  <= reg_wdata_i;
            end else if (commit) begin
                wb_valid <= 1'b0;
            end
            if (commit_write) begin
                retired_o <= retired_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    regfile_array u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (commit_write),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (raddr1_i),
        .raddr2_i (raddr2_i),
        .rdata1_o (arr_rdata1),
        .rdata2_o (arr_rdata2)
    );

`ifdef WB_BYPASS_EN
    // Forward only the registered WB entry, never the raw ex_* inputs, so there is
    // no path from hold_i or ex_valid_i to the read data.
    always_comb begin
        rdata1_o = arr_rdata1;
        rdata2_o = arr_rdata2;
        if (wb_valid && is_reg_write(wb_we, wb_addr) && (wb_addr == raddr1_i)) begin
            rdata1_o = wb_data;
        end
        if (wb_valid && is_reg_write(wb_we, wb_addr) && (wb_addr == raddr2_i)) begin
            rdata2_o = wb_data;
        end
    end
`else
    assign rdata1_o = arr_rdata1;
    assign rdata2_o = arr_rdata2;
`endif

    assign wb_busy_o = wb_valid;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed table-driven bench for wb_regfile

module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        hold;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_busy;
    logic [31:0] retired;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ex_valid_i  (ex_valid),
        .ex_ready_o  (ex_ready),
        .reg_we_i    (reg_we),
        .reg_waddr_i (reg_waddr),
        .reg_wdata_i (reg_wdata),
        .hold_i      (hold),
        .raddr1_i    (raddr1),
        .raddr2_i    (raddr2),
        .rdata1_o    (rdata1),
        .rdata2_o    (rdata2),
        .wb_busy_o   (wb_busy),
        .retired_o   (retired)
    );

    typedef struct {
        logic        v;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        h;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic        e_busy;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic h, input logic [4:0] r1, input logic [4:0] r2,
                       input logic e_rdy, input logic [31:0] e_d1, input logic [31:0] e_d2,
                       input logic e_busy, input logic [31:0] e_ret);
        vec_t t;
        t.v = v; t.we = we; t.wa = wa; t.wd = wd; t.h = h; t.r1 = r1; t.r2 = r2;
        t.e_rdy = e_rdy; t.e_d1 = e_d1; t.e_d2 = e_d2; t.e_busy = e_busy; t.e_ret = e_ret;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid  = 1'b0;
        reg_we    = 1'b0;
        reg_waddr = 5'd0;
        reg_wdata = 32'h0;
        hold      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        raddr1 = 5'd0;
        raddr2 = 5'd0;

        // Expected outputs are observed before the edge that ends each row.
        //   v   we  wa  wd             h   r1  r2    rdy d1                              d2                       busy ret
        add(1, 1, 5, 32'hDEADBEEF, 0, 5, 0,   1, 32'h0,                          32'h0,                   0, 0);
        add(0, 0, 0, 32'h0,        0, 5, 0,   1, BYP ? 32'hDEADBEEF : 32'h0,     32'h0,                   1, 0);
        add(1, 1, 0, 32'h1234,     0, 5, 0,   1, 32'hDEADBEEF,                   32'h0,                   0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 5,   1, 32'h0,                          32'hDEADBEEF,            1, 1);
        add(1, 1, 7, 32'h11,       0, 0, 5,   1, 32'h0,                          32'hDEADBEEF,            0, 1);
        add(1, 1, 8, 32'h22,       1, 7, 8,   0, BYP ? 32'h11 : 32'h0,           32'h0,                   1, 1);
        add(1, 1, 8, 32'h22,       1, 7, 8,   0, BYP ? 32'h11 : 32'h0,           32'h0,                   1, 1);
        add(1, 1, 8, 32'h22,       1, 7, 8,   0, BYP ? 32'h11 : 32'h0,           32'h0,                   1, 1);
        add(1, 1, 8, 32'h22,       0, 7, 8,   1, BYP ? 32'h11 : 32'h0,           32'h0,                   1, 1);
        add(0, 0, 0, 32'h0,        0, 7, 8,   1, 32'h11,                         BYP ? 32'h22 : 32'h0,    1, 2);
        add(1, 1, 1, 32'h1,        0, 1, 8,   1, 32'h0,                          32'h22,                  0, 3);
        add(1, 1, 1, 32'h2,        0, 1, 8,   1, BYP ? 32'h1 : 32'h0,            32'h22,                  1, 3);
        add(1, 1, 1, 32'h3,        0, 1, 8,   1, BYP ? 32'h2 : 32'h1,            32'h22,                  1, 4);
        add(0, 0, 0, 32'h0,        0, 1, 8,   1, BYP ? 32'h3 : 32'h2,            32'h22,                  1, 5);
        add(0, 0, 0, 32'h0,        0, 1, 5,   1, 32'h3,                          32'hDEADBEEF,            0, 6);
        add(1, 0, 5, 32'hFFFF,     0, 5, 0,   1, 32'hDEADBEEF,                   32'h0,                   0, 6);
        add(0, 0, 0, 32'h0,        0, 5, 0,   1, 32'hDEADBEEF,                   32'h0,                   1, 6);
        add(0, 0, 0, 32'h0,        0, 5, 0,   1, 32'hDEADBEEF,                   32'h0,                   0, 6);
        add(1, 1, 2, 32'h55,       1, 2, 7,   1, 32'h0,                          32'h11,                  0, 6);
        add(0, 0, 0, 32'h0,        1, 2, 7,   0, BYP ? 32'h55 : 32'h0,           32'h11,                  1, 6);
        add(0, 0, 0, 32'h0,        0, 2, 7,   1, BYP ? 32'h55 : 32'h0,           32'h11,                  1, 6);
        add(0, 0, 0, 32'h0,        0, 2, 7,   1, 32'h55,                         32'h11,                  0, 7);

        // Reset, then every address reads zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", {31'b0, ex_ready}, 32'h1);
        check("reset_busy", {31'b0, wb_busy}, 32'h0);
        check("reset_retired", retired, 32'h0);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), rdata1, 32'h0);
            check($sformatf("reset_rd2_x%0d", 31 - i), rdata2, 32'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ex_valid  = vecs[i].v;
            reg_we    = vecs[i].we;
            reg_waddr = vecs[i].wa;
            reg_wdata = vecs[i].wd;
            hold      = vecs[i].h;
            raddr1    = vecs[i].r1;
            raddr2    = vecs[i].r2;
            #1;
            check($sformatf("v%0d_ready", i), {31'b0, ex_ready}, {31'b0, vecs[i].e_rdy});
            check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].e_d1);
            check($sformatf("v%0d_rdata2", i), rdata2, vecs[i].e_d2);
            check($sformatf("v%0d_busy", i), {31'b0, wb_busy}, {31'b0, vecs[i].e_busy});
            check($sformatf("v%0d_retired", i), retired, vecs[i].e_ret);
        end

        // Accept x9 then reset before it can commit: entry discarded, state cleared.
        @(negedge clk);
        drive_idle();
        ex_valid  = 1'b1;
        reg_we    = 1'b1;
        reg_waddr = 5'd9;
        reg_wdata = 32'hAA;
        @(negedge clk);
        drive_idle();
        rst    = 1'b1;
        raddr1 = 5'd9;
        raddr2 = 5'd5;
        #1;
        check("pre_rst_busy", {31'b0, wb_busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_x9", rdata1, 32'h0);
        check("rst_x5", rdata2, 32'h0);
        check("rst_busy", {31'b0, wb_busy}, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_ready", {31'b0, ex_ready}, 32'h1);
        @(negedge clk);
        #1;
        check("rst_x9_later", rdata1, 32'h0);
        check("rst_retired_later", retired, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
